baggage_drop_ctrl: RTL

BAGGAGE_DROP_CTRL -- requirements
Module: baggage_drop_ctrl

---
 rtl/baggage_drop_ctrl_pkg.sv | 20 ++
 rtl/baggage_drop_ctrl_stability_checker.sv | 51 +++++
 rtl/baggage_drop_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/baggage_drop_ctrl_pkg.sv
// Shared state encoding (doubles as the display code) and default parameter values
// for the baggage drop controller.
package baggage_drop_ctrl_pkg;

  localparam int unsigned DefStableCycles = 16;
  localparam int unsigned DefTol          = 2;
  localparam int unsigned DefMaxHeight    = 200;
  localparam int unsigned DefDropPulse    = 8;
  localparam int unsigned DefCooldown     = 32;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSettle   = 3'd1,
    StArmed    = 3'd2,
    StDrop     = 3'd3,
    StCooldown = 3'd4,
    StFault    = 3'd5
  } state_e;

endpackage

// File: rtl/baggage_drop_ctrl_stability_checker.sv
// Height deviation compare against the latched reference plus a saturating
// count of consecutive in-tolerance samples.
module baggage_drop_ctrl_stability_checker #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TOL           = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] height,
  input  logic [7:0] ref_height,
  input  logic       load,
  input  logic       incr,
  input  logic       clear,
  output logic       within_tol,
  output logic       reached
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] Target = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] Last   = CntW'(STABLE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      diff, dev;

  // Bit 8 of the 9-bit difference flags height below the reference.
  assign diff       = {1'b0, height} - {1'b0, ref_height};
  assign dev        = diff[8] ? (~diff + 9'd1) : diff;
  assign within_tol = (dev <= 9'(TOL));
  // Asserted when the sample being counted now completes the stable run.
  assign reached    = (cnt_q >= Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CntW'(1);
    end else if (incr && (cnt_q != Target)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/baggage_drop_ctrl.sv
// Baggage drop controller: settles on a stable height, arms, fires a fixed-length
// drop pulse on operator request, then cools down; out-of-range heights fault.
module baggage_drop_ctrl
  import baggage_drop_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned TOL           = DefTol,
  parameter int unsigned MAX_HEIGHT    = DefMaxHeight,
  parameter int unsigned DROP_PULSE    = DefDropPulse,
  parameter int unsigned COOLDOWN      = DefCooldown
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] height,
  input  logic       sample_en,
  input  logic       drop_en,
  output logic       drop_activated,
  output logic [7:0] latched_height,
  output logic [2:0] disp_code
);

  localparam int unsigned TmrMax = (DROP_PULSE > COOLDOWN) ? DROP_PULSE : COOLDOWN;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] DropLast = TmrW'(DROP_PULSE - 1);
  localparam logic [TmrW-1:0] CoolLast = TmrW'(COOLDOWN - 1);
  localparam logic [7:0]      MaxH     = 8'(MAX_HEIGHT);

  state_e          state_q, state_d;
  logic [7:0]      latch_q, latch_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            drop_q;
  logic            load, incr, within_tol, reached;

  baggage_drop_ctrl_stability_checker #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .TOL          (TOL)
  ) u_stability_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .height    (height),
    .ref_height(latch_q),
    .load      (load),
    .incr      (incr),
    .clear     (state_d != StSettle),
    .within_tol(within_tol),
    .reached   (reached)
  );

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    tmr_d   = tmr_q;
    load    = 1'b0;
    incr    = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample_en) begin
          if (height > MaxH) begin
            state_d = StFault;
          end else if (height != 8'd0) begin
            state_d = StSettle;
            latch_d = height;
            load    = 1'b1;
          end
        end
      end
      StSettle: begin
        if (sample_en) begin
          if (height == 8'd0) begin
            state_d = StIdle;
          end else if (height > MaxH) begin
            state_d = StFault;
          end else if (!within_tol) begin
            latch_d = height;
            load    = 1'b1;
          end else begin
            incr = 1'b1;
            if (reached) state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (sample_en) begin
          if (height == 8'd0) begin
            state_d = StIdle;
          end else if ((height > MaxH) || !within_tol) begin
            // Over-height re-settles here; the next SETTLE sample raises the fault.
            state_d = StSettle;
            latch_d = height;
            load    = 1'b1;
          end else if (drop_en) begin
            state_d = StDrop;
            tmr_d   = '0;
          end
        end
      end
      StDrop: begin
        if (tmr_q >= DropLast) begin
          state_d = StCooldown;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StCooldown: begin
        if (tmr_q >= CoolLast) begin
          state_d = StIdle;
          tmr_d   = '0;
          latch_d = 8'd0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StFault: begin
        if (sample_en && (height == 8'd0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      latch_q <= 8'd0;
      tmr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      tmr_q   <= tmr_d;
      drop_q  <= (state_d == StDrop);
    end
  end

  assign drop_activated = drop_q;
  assign latched_height = latch_q;
  assign disp_code      = state_q;

endmodule
